// File: rtl/core_seq_ctrl_pkg.sv
// Shared types and constants for the multi-cycle core sequencer.
package core_seq_ctrl_pkg;

    // Address bit that separates RAM (1) from device space (0).
    localparam int DEV_ADDR_BIT = 31;

    // Encodings are fixed so external debug tooling can decode the state.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_MEM   = 3'd3,
        S_WB    = 3'd4,
        S_HALT  = 3'd5
    } ctrl_state_t;

    // A memory access is a device access when the RAM-select bit is clear.
    function automatic logic is_dev_access(input logic ram_bit, input logic mem_op);
        return ~ram_bit & mem_op;
    endfunction

endpackage

// File: rtl/core_seq_ctrl_if.sv
// Instruction-bus and data-bus valid/data_ok handshakes between the
// sequencer (master) and the memory side (slave).
interface core_seq_ctrl_if;
    logic ireq_valid;
    logic iresp_data_ok;
    logic dreq_valid;
    logic dresp_data_ok;

    modport master (
        output ireq_valid,
        output dreq_valid,
        input  iresp_data_ok,
        input  dresp_data_ok
    );

    modport slave (
        input  ireq_valid,
        input  dreq_valid,
        output iresp_data_ok,
        output dresp_data_ok
    );
endinterface

// File: rtl/core_seq_ctrl_seq_counter.sv
// Free-running enabled counter with asynchronous clear and a synchronous
// preload; wraps modulo 2^CNT_W.
module seq_counter #(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] q
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Count register: preload wins over increment.
    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            q <= '0;
        else if (load)
            q <= load_val;
        else if (en)
            q <= q + ONE;
    end

endmodule

// File: rtl/core_seq_ctrl.sv
// Multi-cycle sequencer: FETCH -> EXEC -> (MEM) -> WB per instruction,
// owning the bus valids, datapath write enables and commit/trap/counter
// signals for the difftest hooks.
module core_seq_ctrl
    import core_seq_ctrl_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             reset,
    core_seq_ctrl_if.master  bus,
    input  logic [XLEN-1:0]  pc_i,
    input  logic [XLEN-1:0]  mem_addr_i,
    input  logic             dec_mem_rd,
    input  logic             dec_mem_wr,
    input  logic             dec_reg_wr,
    input  logic             dec_halt,
    output logic             ir_we,
    output logic             pc_we,
    output logic             rf_we,
    output logic             commit_valid,
    output logic [XLEN-1:0]  commit_pc,
    output logic             commit_skip,
    output logic             trap_valid,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    ctrl_state_t state;
    ctrl_state_t state_next;
    logic        mem_q;
    logic        reg_wr_q;
    logic        skip_q;
    logic        trap_done;
    logic        unused_addr_bits;

    // Only the RAM-select bit of the address matters here.
    assign unused_addr_bits = ^{mem_addr_i[XLEN-1:DEV_ADDR_BIT+1],
                                mem_addr_i[DEV_ADDR_BIT-1:0]};

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    // Next-state logic; halt outranks a memory op decoded alongside it.
    // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  state_next = S_FETCH;
            S_FETCH: if (bus.iresp_data_ok) state_next = S_EXEC;
            S_EXEC: begin
                if (dec_halt)
                    state_next = S_HALT;
                else if (dec_mem_rd || dec_mem_wr)
                    state_next = S_MEM;
                else
                    state_next = S_WB;
            end
            S_MEM:   if (bus.dresp_data_ok) state_next = S_WB;
            S_WB:    state_next = S_FETCH;
            S_HALT:  state_next = S_HALT;
            default: state_next = S_IDLE;
        endcase
    end

    // Decode results captured in EXEC so WB does not depend on the decoder.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q    <= 1'b0;
            reg_wr_q <= 1'b0;
            skip_q   <= 1'b0;
        end else if (state == S_EXEC) begin
            mem_q    <= dec_mem_rd | dec_mem_wr;
            reg_wr_q <= dec_reg_wr;
            skip_q   <= is_dev_access(mem_addr_i[DEV_ADDR_BIT], dec_mem_rd | dec_mem_wr);
        end
    end

    // PC captured on entry to WB so it is stable while the PC advances.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            commit_pc <= '0;
        else if (state_next == S_WB && state != S_WB)
            commit_pc <= pc_i;
    end

    // Marks that the one-cycle trap pulse has been issued.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            trap_done <= 1'b0;
        else if (state == S_HALT)
            trap_done <= 1'b1;
    end

    assign bus.ireq_valid = (state == S_FETCH);
    assign bus.dreq_valid = (state == S_MEM);
    assign ir_we          = (state == S_FETCH) & bus.iresp_data_ok;
    assign pc_we          = (state == S_WB);
    assign rf_we          = (state == S_WB) & reg_wr_q;
    assign commit_valid   = (state == S_WB);
    assign commit_skip    = (state == S_WB) & skip_q & mem_q;
    assign trap_valid     = (state == S_HALT) & ~trap_done;

    seq_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
        .clk      (clk),
        .reset    (reset),
        .en       (1'b1),
        .load     (1'b0),
        .load_val ('0),
        .q        (cycle_cnt)
    );

    seq_counter #(.CNT_W(CNT_W)) u_instr_cnt (
        .clk      (clk),
        .reset    (reset),
        .en       (commit_valid),
        .load     (1'b0),
        .load_val ('0),
        .q        (instr_cnt)
    );

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Scoreboard bench for core_seq_ctrl: the driver pushes the expected
// commit/trap for each instruction, a negedge monitor pops and compares.
module tb_core_seq_ctrl;

    localparam int          XLEN    = 64;
    localparam int          CNT_W   = 64;
    localparam logic [63:0] PC_BASE = 64'h0000_0000_8000_0000;

    typedef struct packed {
        logic        is_trap;
        logic [63:0] pc;
        logic        skip;
        logic        rf;
        logic [63:0] icnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    core_seq_ctrl_if bus ();

    logic [XLEN-1:0]  pc_reg;
    logic [XLEN-1:0]  mem_addr_i = '0;
    logic             dec_mem_rd = 1'b0, dec_mem_wr = 1'b0, dec_reg_wr = 1'b0, dec_halt = 1'b0;
    logic             ir_we, pc_we, rf_we, commit_valid, commit_skip, trap_valid;
    logic [XLEN-1:0]  commit_pc;
    logic [CNT_W-1:0] cycle_cnt, instr_cnt;

    logic             w_en = 1'b0, w_load = 1'b0;
    logic [63:0]      w_val = '0;
    logic [63:0]      w_q;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_pc = PC_BASE;
    logic [63:0] n_commit = '0;
    logic        tie_iresp = 1'b0;
    logic [63:0] c0;

    core_seq_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .pc_i         (pc_reg),
        .mem_addr_i   (mem_addr_i),
        .dec_mem_rd   (dec_mem_rd),
        .dec_mem_wr   (dec_mem_wr),
        .dec_reg_wr   (dec_reg_wr),
        .dec_halt     (dec_halt),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .rf_we        (rf_we),
        .commit_valid (commit_valid),
        .commit_pc    (commit_pc),
        .commit_skip  (commit_skip),
        .trap_valid   (trap_valid),
        .cycle_cnt    (cycle_cnt),
        .instr_cnt    (instr_cnt)
    );

    seq_counter #(.CNT_W(64)) u_wrap (
        .clk      (clk),
        .reset    (reset),
        .en       (w_en),
        .load     (w_load),
        .load_val (w_val),
        .q        (w_q)
    );

    // PC register of the surrounding datapath.
    always @(posedge clk or posedge reset) begin
        if (reset)
            pc_reg <= PC_BASE;
        else if (pc_we)
            pc_reg <= pc_reg + 64'd4;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: invariants every cycle, scoreboard pop on commit/trap.
    always @(negedge clk) begin
        if (!reset) begin
            check1("ireq_dreq_exclusive", bus.ireq_valid & bus.dreq_valid, 1'b0);
            check1("pc_we_only_in_wb", pc_we & ~commit_valid, 1'b0);
            check1("rf_we_only_in_wb", rf_we & ~commit_valid, 1'b0);
            check1("ir_we_only_in_fetch", ir_we & ~bus.ireq_valid, 1'b0);
            if (commit_valid || trap_valid) begin
                if (exp_q.size() == 0) begin
                    check1("unexpected_commit", commit_valid, 1'b0);
                    check1("unexpected_trap", trap_valid, 1'b0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check1("event_is_trap", trap_valid, mon_e.is_trap);
                    check1("event_is_commit", commit_valid, ~mon_e.is_trap);
                    if (!mon_e.is_trap) begin
                        check("commit_pc", commit_pc, mon_e.pc);
                        check1("commit_skip", commit_skip, mon_e.skip);
                        check1("rf_we", rf_we, mon_e.rf);
                        check1("pc_we", pc_we, 1'b1);
                        check("instr_cnt_at_commit", instr_cnt, mon_e.icnt);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fetch();
        for (int i = 0; i < 20 && !bus.ireq_valid; i++) tick();
        check1("fetch_request_seen", bus.ireq_valid, 1'b1);
    endtask

    // Assert reset, check the reset state, release, check IDLE -> FETCH.
    task automatic do_reset();
        reset = 1'b1;
        bus.iresp_data_ok = 1'b1;
        bus.dresp_data_ok = 1'b1;
        tick();
        tick();
        check1("rst_ireq_valid", bus.ireq_valid, 1'b0);
        check1("rst_dreq_valid", bus.dreq_valid, 1'b0);
        check1("rst_ir_we", ir_we, 1'b0);
        check1("rst_commit_valid", commit_valid, 1'b0);
        check1("rst_trap_valid", trap_valid, 1'b0);
        check1("rst_pc_we", pc_we, 1'b0);
        check1("rst_rf_we", rf_we, 1'b0);
        check("rst_commit_pc", commit_pc, 64'd0);
        check("rst_cycle_cnt", cycle_cnt, 64'd0);
        check("rst_instr_cnt", instr_cnt, 64'd0);
        bus.iresp_data_ok = 1'b0;
        bus.dresp_data_ok = 1'b0;
        exp_q.delete();
        exp_pc = PC_BASE;
        n_commit = '0;
        reset = 1'b0;
        #1;
        check1("idle_no_ireq", bus.ireq_valid, 1'b0);
        tick();
        check1("cycle1_ireq", bus.ireq_valid, 1'b1);
        check("cycle1_cycle_cnt", cycle_cnt, 64'd1);
    endtask

    // One instruction; the expected commit (or trap) is queued up front.
    task automatic run_instr(input int fetch_wait, input logic rd, input logic wr,
                             input logic reg_wr, input logic halt, input logic [63:0] addr,
                             input int mem_wait, input logic exp_skip);
        exp_t e;
        wait_fetch();
        e.is_trap = halt;
        e.pc      = halt ? 64'd0 : exp_pc;
        e.skip    = exp_skip;
        e.rf      = reg_wr;
        e.icnt    = n_commit;
        exp_q.push_back(e);
        if (!halt) begin
            exp_pc   = exp_pc + 64'd4;
            n_commit = n_commit + 64'd1;
        end
        for (int k = 0; k < fetch_wait; k++) begin
            bus.iresp_data_ok = 1'b0;
            #1;
            check1("fetch_stall_ireq", bus.ireq_valid, 1'b1);
            check1("fetch_stall_ir_we", ir_we, 1'b0);
            tick();
        end
        bus.iresp_data_ok = 1'b1;
        #1;
        check1("fetch_ok_ireq", bus.ireq_valid, 1'b1);
        check1("fetch_ok_ir_we", ir_we, 1'b1);
        tick();
        if (!tie_iresp) bus.iresp_data_ok = 1'b0;
        dec_mem_rd = rd;
        dec_mem_wr = wr;
        dec_reg_wr = reg_wr;
        dec_halt   = halt;
        mem_addr_i = addr;
        #1;
        check1("exec_ir_we_ignored", ir_we, 1'b0);
        check1("exec_no_ireq", bus.ireq_valid, 1'b0);
        tick();
        dec_mem_rd = 1'b0;
        dec_mem_wr = 1'b0;
        dec_reg_wr = 1'b0;
        dec_halt   = 1'b0;
        mem_addr_i = '0;
        if (!halt) begin
            if (rd || wr) begin
                for (int k = 0; k < mem_wait; k++) begin
                    check1("mem_dreq_hold", bus.dreq_valid, 1'b1);
                    if (k == mem_wait - 1) bus.dresp_data_ok = 1'b1;
                    tick();
                    bus.dresp_data_ok = 1'b0;
                end
            end
            check1("wb_no_dreq", bus.dreq_valid, 1'b0);
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.iresp_data_ok = 1'b0;
        bus.dresp_data_ok = 1'b0;

        // 1: back-to-back ALU instructions with iresp_data_ok tied high.
        do_reset();
        tie_iresp = 1'b1;
        bus.iresp_data_ok = 1'b1;
        for (int i = 0; i < 3; i++) run_instr(0, 1'b0, 1'b0, 1'b1, 1'b0, 64'd0, 0, 1'b0);
        check("alu_cycle_cnt_after_3", cycle_cnt, 64'd10);
        check("alu_instr_cnt_after_3", instr_cnt, 64'd3);
        check("commit_pc_holds", commit_pc, 64'h0000_0000_8000_0008);
        tie_iresp = 1'b0;
        bus.iresp_data_ok = 1'b0;

        // 2: fetch stall, data_ok on the fourth request cycle.
        run_instr(3, 1'b0, 1'b0, 1'b1, 1'b0, 64'd0, 0, 1'b0);

        // 3: load to RAM (no skip), store to device space (skip, no rf write).
        run_instr(0, 1'b1, 1'b0, 1'b1, 1'b0, 64'h0000_0000_8000_1000, 2, 1'b0);
        run_instr(1, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0000_0000_1000_0000, 1, 1'b1);
        check("instr_cnt_after_6", instr_cnt, 64'd6);

        // 4: halt decoded together with a load.
        run_instr(0, 1'b1, 1'b0, 1'b1, 1'b1, 64'h0000_0000_8000_2000, 0, 1'b0);
        check1("halt_trap_now", trap_valid, 1'b1);
        c0 = cycle_cnt;
        for (int k = 0; k < 4; k++) begin
            bus.dresp_data_ok = 1'b1;
            bus.iresp_data_ok = 1'b1;
            tick();
            check1("halt_no_dreq", bus.dreq_valid, 1'b0);
            check1("halt_no_ireq", bus.ireq_valid, 1'b0);
            check1("halt_trap_once", trap_valid, 1'b0);
        end
        bus.dresp_data_ok = 1'b0;
        bus.iresp_data_ok = 1'b0;
        check("halt_cycle_cnt_runs", cycle_cnt, c0 + 64'd4);
        check("halt_instr_cnt_frozen", instr_cnt, n_commit);

        // 5: reset asserted while a load is waiting in MEM.
        do_reset();
        wait_fetch();
        bus.iresp_data_ok = 1'b1;
        tick();
        bus.iresp_data_ok = 1'b0;
        dec_mem_rd = 1'b1;
        mem_addr_i = 64'h0000_0000_8000_3000;
        tick();
        dec_mem_rd = 1'b0;
        check1("pre_reset_dreq", bus.dreq_valid, 1'b1);
        reset = 1'b1;
        #1;
        check1("async_reset_dreq", bus.dreq_valid, 1'b0);
        check1("async_reset_ireq", bus.ireq_valid, 1'b0);
        check("async_reset_cycle_cnt", cycle_cnt, 64'd0);
        check("async_reset_instr_cnt", instr_cnt, 64'd0);
        tick();
        exp_q.delete();
        exp_pc = PC_BASE;
        n_commit = '0;
        bus.dresp_data_ok = 1'b1;
        reset = 1'b0;
        #1;
        check1("post_reset_idle_ireq", bus.ireq_valid, 1'b0);
        check1("post_reset_idle_dreq", bus.dreq_valid, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check1("post_reset_fetch_ireq", bus.ireq_valid, 1'b1);
            check1("late_dresp_ignored", bus.dreq_valid, 1'b0);
        end
        bus.dresp_data_ok = 1'b0;
        run_instr(0, 1'b0, 1'b0, 1'b1, 1'b0, 64'd0, 0, 1'b0);
        check("recovered_instr_cnt", instr_cnt, 64'd1);

        // 6: counter wraps from all-ones to zero.
        w_val  = 64'hFFFF_FFFF_FFFF_FFFF;
        w_load = 1'b1;
        tick();
        w_load = 1'b0;
        check("wrap_preload", w_q, 64'hFFFF_FFFF_FFFF_FFFF);
        w_en = 1'b1;
        tick();
        w_en = 1'b0;
        check("wrap_to_zero", w_q, 64'd0);

        tick();
        check1("scoreboard_drained", exp_q.size() == 0, 1'b1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/core_seq_ctrl.md
Name: core_seq_ctrl

Overview:
- Multi-cycle sequencer for the single-issue core: one instruction at a time through FETCH, EXEC, MEM and WB.
- Owns the ibus/dbus valid handshakes.
- Drives the write enables for the PC, instruction and register file.
- Produces commit/trap/counter signals consumed by the difftest hooks in core.

Parameters:
XLEN, 64, datapath/PC width
CNT_W, 64, width of cycle and instruction counters

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
ireq_valid  out  1  instruction fetch request valid
iresp_data_ok  in  1  fetch data returned this cycle
dreq_valid  out  1  data access request valid
dresp_data_ok  in  1  data access complete this cycle
pc_i  in  XLEN  current PC from PC register
mem_addr_i  in  XLEN  effective address of current load/store
dec_mem_rd  in  1  decoded instr is a load
dec_mem_wr  in  1  decoded instr is a store
dec_reg_wr  in  1  decoded instr writes rd
dec_halt  in  1  decoded instr is the halt/trap marker
ir_we  out  1  latch fetched instruction into IR
pc_we  out  1  advance PC to next-PC
rf_we  out  1  register-file write enable
commit_valid  out  1  instruction committed this cycle
commit_pc  out  XLEN  PC of committed instruction
commit_skip  out  1  committed access targets device space
trap_valid  out  1  halt reached (one-cycle pulse)
cycle_cnt  out  CNT_W  cycles since reset
instr_cnt  out  CNT_W  instructions committed since reset

Behaviour:
- Clocking and reset: clk only. reset is asynchronous, active-high.
- Reset values:
  - State = S_IDLE.
  - All outputs 0, including commit_pc, cycle_cnt and instr_cnt.
- Outputs are Moore outputs of the state, except ir_we, which is gated by iresp_data_ok.
- S_IDLE: one cycle after reset deassertion, then S_FETCH. ireq_valid=0.
- S_FETCH:
  - ireq_valid=1, held continuously until iresp_data_ok; never dropped mid-request.
  - On iresp_data_ok: ir_we=1 that cycle, next state S_EXEC.
- S_EXEC: one cycle; decoded signals sampled here. Next state:
  - dec_halt → S_HALT (takes priority).
  - dec_mem_rd or dec_mem_wr → S_MEM.
  - Otherwise → S_WB.
  - The controller latches dec_mem_rd|dec_mem_wr, dec_reg_wr and skip = ~mem_addr_i[31] & (rd|wr) into internal registers.
- S_MEM:
  - dreq_valid=1, held until dresp_data_ok.
  - On dresp_data_ok → S_WB.
- S_WB: single-cycle pulses, then S_FETCH.
  - rf_we=latched reg_wr, pc_we=1, commit_valid=1.
  - commit_pc=pc_i, registered so it stays stable during the pulse; it holds its value afterwards.
  - commit_skip=latched skip.
- S_HALT:
  - trap_valid pulses exactly one cycle on entry.
  - The block then remains in S_HALT until reset; ireq_valid=dreq_valid=0.
  - The halt instruction is not committed.
- Latency: ALU instruction = 1 (FETCH, with same-cycle data_ok) + 1 EXEC + 1 WB = 3 cycles minimum. Load/store adds ≥1 MEM cycle.
- Counters:
  - cycle_cnt increments every cycle not in reset, including S_HALT.
  - instr_cnt increments when commit_valid=1.
  - Both wrap modulo 2^CNT_W without saturation.
- Simultaneous events: iresp_data_ok outside S_FETCH and dresp_data_ok outside S_MEM are ignored.
- Reset mid-access: immediate return to S_IDLE; valids drop asynchronously; counters clear; any in-flight response is ignored.
- Never both ireq_valid and dreq_valid high in the same cycle.
- pc_we and rf_we are asserted only in S_WB.

Decomposition:
- common package holds:
  - ctrl_state_t enum (S_IDLE, S_FETCH, S_EXEC, S_MEM, S_WB, S_HALT).
  - Localparam DEV_ADDR_BIT=31.
- Natural sub-module: seq_counter (CNT_W-bit enabled counter with async clear), instantiated twice for cycle_cnt and instr_cnt.

Test Plan:
1. Reset released, iresp_data_ok tied 1, ALU instr (dec_reg_wr=1):
   - ireq_valid at cycle 1, commit_valid and rf_we at cycle 3.
   - Commit repeats every 3 cycles; instr_cnt=3 after 3 commits.
2. Fetch stall, data_ok after 4 cycles:
   - ireq_valid stays 1 for all 4 cycles.
   - ir_we pulses only on the data_ok cycle.
3. Load, mem_addr_i=0x8000_1000, dresp_data_ok after 2 cycles:
   - dreq_valid high 2 cycles, then commit_valid with commit_skip=0.
   - Store to 0x1000_0000 gives commit_skip=1 and rf_we=0.
4. dec_halt with dec_mem_rd=1 in EXEC:
   - trap_valid pulses once, no dreq_valid, no commit.
   - cycle_cnt keeps incrementing; instr_cnt frozen.
5. Reset asserted while dreq_valid=1:
   - Same cycle: dreq_valid=0, counters=0.
   - After release, a late dresp_data_ok is ignored and fetch restarts from S_IDLE→S_FETCH.
6. Preload counter sub-module to 2^64-1 and commit once: instr_cnt wraps to 0.
